// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared widths, FSM state encoding and error codes for wave_analyzer
package wave_pkg;

  localparam int SAMPLE_W = 10;
  localparam int CNT_W    = 16;
  localparam int THR_W    = 11;

  typedef logic        [SAMPLE_W-1:0] sample_t;
  typedef logic signed [THR_W-1:0]    thr_t;
  typedef logic        [CNT_W-1:0]    cnt_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACQ  = 3'd1;
  localparam logic [2:0] ST_SEEK = 3'd2;
  localparam logic [2:0] ST_MEAS = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_FLAT    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam cnt_t CNT_MAX = '1;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wave_analyzer_crossing_detect.sv
// rtl/wave_analyzer_crossing_detect.sv - hysteresis rising-crossing detector
// Arms below lo, fires a combinational one-sample pulse at or above hi, then disarms.
module crossing_detect
  import wave_pkg::*;
(
  input  logic    clk_50MHz,
  input  logic    rst,
  input  sample_t sample,
  input  logic    valid,
  input  thr_t    lo,
  input  thr_t    hi,
  input  logic    clear,
  output logic    rise
);

  logic armed_q, armed_d;
  thr_t sample_s;

  assign sample_s = $signed({1'b0, sample});
  assign rise     = valid && !clear && armed_q && (sample_s >= hi);

  always_comb begin
    armed_d = armed_q;
    if (clear) begin
      armed_d = 1'b0;
    end else if (rise) begin
      armed_d = 1'b0;
    end else if (valid && (sample_s < lo)) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/wave_analyzer.sv
// rtl/wave_analyzer.sv - min/max window plus averaged-period measurement of a sampled waveform
// Optional WAVE_ANALYZER_TIMEOUT_EN: abort SEEK/MEAS with err=10 when the sample counter saturates.
module wave_analyzer
  import wave_pkg::*;
#(
  parameter int WIN_LEN = 1024,
  parameter int N_PER   = 4,
  parameter int HYST    = 8
) (
  input  logic                clk_50MHz,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic                data_in_en,
  input  logic                meas_start,
  output logic                busy,
  output logic                meas_valid,
  output logic [SAMPLE_W-1:0] vmax,
  output logic [SAMPLE_W-1:0] vmin,
  output logic [CNT_W-1:0]    period,
  output logic [1:0]          err
);

  localparam int            PER_SHIFT = $clog2(N_PER);
  localparam thr_t          HYST_T    = thr_t'(HYST);
  localparam logic [SAMPLE_W:0] FLAT_LIM = (SAMPLE_W+1)'(2 * HYST);
  localparam cnt_t          WIN_LAST  = cnt_t'(WIN_LEN - 1);
  localparam logic [4:0]    XING_LAST = 5'(N_PER - 1);

  logic [2:0]  state_q, state_d;
  sample_t     run_max_q, run_max_d, run_min_q, run_min_d;
  sample_t     vmax_q, vmax_d, vmin_q, vmin_d;
  thr_t        lo_q, lo_d, hi_q, hi_d;
  cnt_t        cnt_q, cnt_d, period_q, period_d;
  logic [4:0]  xcnt_q, xcnt_d;
  logic [1:0]  err_q, err_d;
  logic        valid_q, valid_d;

  sample_t         new_max, new_min;
  logic [SAMPLE_W:0] sum, span;
  sample_t         mid;
  logic            flat, tracking, rise, tmo;
  cnt_t            cnt_inc;

  assign new_max  = (data_in > run_max_q) ? data_in : run_max_q;
  assign new_min  = (data_in < run_min_q) ? data_in : run_min_q;
  assign sum      = {1'b0, new_max} + {1'b0, new_min};
  assign span     = {1'b0, new_max} - {1'b0, new_min};
  assign mid      = sum[SAMPLE_W:1];
  assign flat     = (span < FLAT_LIM);
  assign tracking = (state_q == ST_SEEK) || (state_q == ST_MEAS);
  assign cnt_inc  = sat_inc(cnt_q);

`ifdef WAVE_ANALYZER_TIMEOUT_EN
  assign tmo = (cnt_inc == CNT_MAX);
`else
  assign tmo = 1'b0;
`endif

  crossing_detect u_xdet (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .sample    (data_in),
    .valid     (data_in_en && tracking),
    .lo        (lo_q),
    .hi        (hi_q),
    .clear     (!tracking),
    .rise      (rise)
  );

  always_comb begin
    state_d   = state_q;
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    vmax_d    = vmax_q;
    vmin_d    = vmin_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    xcnt_d    = xcnt_q;
    period_d  = period_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (meas_start) begin
          state_d   = ST_ACQ;
          err_d     = ERR_OK;
          period_d  = '0;
          run_max_d = '0;
          run_min_d = '1;
          cnt_d     = '0;
          xcnt_d    = '0;
        end
      end
      ST_ACQ: begin
        if (data_in_en) begin
          run_max_d = new_max;
          run_min_d = new_min;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == WIN_LAST) begin
            vmax_d = new_max;
            vmin_d = new_min;
            lo_d   = $signed({1'b0, mid}) - HYST_T;
            hi_d   = $signed({1'b0, mid}) + HYST_T;
            cnt_d  = '0;
            if (flat) begin
              state_d  = ST_DONE;
              err_d    = ERR_FLAT;
              period_d = '0;
              valid_d  = 1'b1;
            end else begin
              state_d = ST_SEEK;
            end
          end
        end
      end
      ST_SEEK, ST_MEAS: begin
        if (data_in_en) begin
          cnt_d = cnt_inc;
          // A crossing wins over a same-sample saturation timeout.
          if (rise && (state_q == ST_SEEK)) begin
            state_d = ST_MEAS;
            cnt_d   = cnt_t'(1);
            xcnt_d  = '0;
          end else if (rise && (xcnt_q == XING_LAST)) begin
            state_d  = ST_DONE;
            period_d = cnt_q >> PER_SHIFT;
            valid_d  = 1'b1;
          end else if (rise) begin
            xcnt_d = xcnt_q + 1'b1;
          end else if (tmo) begin
            state_d  = ST_DONE;
            err_d    = ERR_TIMEOUT;
            period_d = CNT_MAX;
            valid_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      run_max_q <= '0;
      run_min_q <= '1;
      vmax_q    <= '0;
      vmin_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      xcnt_q    <= '0;
      period_q  <= '0;
      err_q     <= ERR_OK;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      vmax_q    <= vmax_d;
      vmin_q    <= vmin_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      xcnt_q    <= xcnt_d;
      period_q  <= period_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
    end
  end

  assign busy       = (state_q == ST_ACQ) || tracking;
  assign meas_valid = valid_q;
  assign vmax       = vmax_q;
  assign vmin       = vmin_q;
  assign period     = period_q;
  assign err        = err_q;

endmodule

// File: tb/tb_wave_analyzer.sv
// tb/tb_wave_analyzer.sv - table-driven bench for wave_analyzer with default parameters
module tb_wave_analyzer;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  data_in = '0;
  logic        data_in_en = 1'b0;
  logic        meas_start = 1'b0;
  logic        busy, meas_valid;
  logic [9:0]  vmax, vmin;
  logic [15:0] period;
  logic [1:0]  err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int kind;
    int div;
    int budget;
    int vmax;
    int vmin;
    int period;
    int err;
  } vec_t;

  vec_t vecs[4];

  wave_analyzer dut (
    .clk_50MHz  (clk_50MHz),
    .rst        (rst),
    .data_in    (data_in),
    .data_in_en (data_in_en),
    .meas_start (meas_start),
    .busy       (busy),
    .meas_valid (meas_valid),
    .vmax       (vmax),
    .vmin       (vmin),
    .period     (period),
    .err        (err)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // 0 sawtooth 0..1023 /128, 1 flat 512, 2 sine /256, 3 noisy square /100, 4 ramp then hold high
  function automatic logic [9:0] wave(input int kind, input int i);
    real r;
    int  v;
    case (kind)
      0: v = ((i % 128) * 1023) / 127;
      1: v = 512;
      2: begin
        r = 512.0 + 500.0 * $sin(6.283185307179586 * real'(i % 256) / 256.0);
        v = $rtoi(r + 0.5);
      end
      3: v = (((i % 100) < 50) ? 800 : 200) + (i % 11) - 5;
      default: v = (i < 1024) ? i : 1023;
    endcase
    return 10'(v);
  endfunction

  task automatic run_vec(input int kind, input int div, input int budget, output bit got);
    int idx = 0;
    int cyc = 0;
    got = 1'b0;
    @(posedge clk_50MHz); #1;
    meas_start = 1'b1;
    data_in_en = 1'b0;
    @(posedge clk_50MHz); #1;
    meas_start = 1'b0;
    while (!got && (cyc < budget)) begin
      data_in_en = ((cyc % div) == 0);
      data_in    = wave(kind, idx);
      if (data_in_en) idx++;
      @(posedge clk_50MHz); #1;
      cyc++;
      if (meas_valid) got = 1'b1;
    end
    data_in_en = 1'b0;
  endtask

  initial begin
    bit got;

    vecs[0] = '{kind: 0, div: 1, budget: 3000,  vmax: 1023, vmin: 0,   period: 128, err: 0};
    vecs[1] = '{kind: 1, div: 1, budget: 2000,  vmax: 512,  vmin: 512, period: 0,   err: 1};
    vecs[2] = '{kind: 2, div: 3, budget: 9000,  vmax: 1012, vmin: 12,  period: 256, err: 0};
    vecs[3] = '{kind: 3, div: 1, budget: 3000,  vmax: 805,  vmin: 195, period: 100, err: 0};

    repeat (3) @(posedge clk_50MHz);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_vmax", int'(vmax), 0);
    chk("rst_vmin", int'(vmin), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i].kind, vecs[i].div, vecs[i].budget, got);
      chk($sformatf("v%0d_valid", i), int'(got), 1);
      chk($sformatf("v%0d_vmax", i), int'(vmax), vecs[i].vmax);
      chk($sformatf("v%0d_vmin", i), int'(vmin), vecs[i].vmin);
      chk($sformatf("v%0d_period", i), int'(period), vecs[i].period);
      chk($sformatf("v%0d_err", i), int'(err), vecs[i].err);
      @(posedge clk_50MHz); #1;
      chk($sformatf("v%0d_pulse", i), int'(meas_valid), 0);
      chk($sformatf("v%0d_idle", i), int'(busy), 0);
    end

    // Restart in the same cycle as meas_valid, then abort mid-MEAS with rst.
    run_vec(1, 1, 2000, got);
    chk("flat2_valid", int'(got), 1);
    meas_start = 1'b1;
    @(posedge clk_50MHz); #1;
    meas_start = 1'b0;
    chk("restart_busy", int'(busy), 1);
    chk("restart_err_clr", int'(err), 0);
    for (int i = 0; i < 1250; i++) begin
      data_in_en = 1'b1;
      data_in    = wave(0, i);
      @(posedge clk_50MHz); #1;
    end
    chk("meas_busy", int'(busy), 1);
    rst        = 1'b1;
    meas_start = 1'b1;
    @(posedge clk_50MHz); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(meas_valid), 0);
    chk("abort_vmax", int'(vmax), 0);
    chk("abort_period", int'(period), 0);
    rst        = 1'b0;
    meas_start = 1'b0;
    data_in_en = 1'b0;
    @(posedge clk_50MHz); #1;
    chk("abort_stay_idle", int'(busy), 0);
    run_vec(0, 1, 3000, got);
    chk("fresh_valid", int'(got), 1);
    chk("fresh_period", int'(period), 128);
    chk("fresh_vmax", int'(vmax), 1023);
    chk("fresh_err", int'(err), 0);

`ifdef WAVE_ANALYZER_TIMEOUT_EN
    run_vec(4, 1, 67000, got);
    chk("tmo_valid", int'(got), 1);
    chk("tmo_err", int'(err), 2);
    chk("tmo_period", int'(period), 65535);
`else
    run_vec(4, 1, 66700, got);
    chk("tmo_no_valid", int'(got), 0);
    chk("tmo_busy", int'(busy), 1);
    chk("tmo_err", int'(err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_analyzer.md
WAVE_ANALYZER -- requirements
Module: wave_analyzer

Interface
REQ-001 Parameter WIN_LEN, default 1024: samples in min/max acquisition window, power of 2, 16 to 32768.
REQ-002 Parameter N_PER, default 4: periods averaged per measurement, power of 2, 1 to 16.
REQ-003 Parameter HYST, default 8: crossing hysteresis in LSB, 0 to 63.
REQ-004 clk_50MHz  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 data_in  in  10  unsigned waveform sample, as produced on the generator's data_out.
REQ-007 data_in_en  in  1  sample qualifier; only cycles with data_in_en=1 are samples.
REQ-008 meas_start  in  1  single-cycle start pulse; ignored unless state is IDLE or DONE.
REQ-009 busy  out  1  high in ACQ, SEEK, MEAS.
REQ-010 meas_valid  out  1  one-cycle pulse on entry to DONE.
REQ-011 vmax, vmin  out  10 each  window maximum and minimum.
REQ-012 period  out  16  average period in samples.
REQ-013 err  out  2  00 ok, 01 flat signal, 10 timeout.

Function
REQ-014 FSM states IDLE, ACQ, SEEK, MEAS, DONE; meas_start in IDLE/DONE -> ACQ next cycle, clearing err, period, and the running min/max (min=1023, max=0).
REQ-015 ACQ: each sample updates running max/min; after WIN_LEN samples, vmax/vmin registered, mid=(vmax+vmin)>>1 from an 11-bit sum, then -> SEEK.
REQ-016 If vmax-vmin < 2*HYST at end of ACQ: err=01, -> DONE, period=0.
REQ-017 Thresholds hi=mid+HYST, lo=mid-HYST, computed at 11 bits signed; no wrap.
REQ-018 Crossing detector: armed when sample < lo; rising crossing = armed and sample >= hi; detection disarms.
REQ-019 SEEK: first rising crossing -> MEAS, 16-bit sample counter loaded to 1 on that sample.
REQ-020 MEAS: counter +1 per sample; each later rising crossing increments a crossing count; the N_PER-th -> DONE, period = counter >> log2(N_PER).
REQ-021 Counter increments saturate at 0xFFFF; never wraps.
REQ-022 Non-sample cycles (data_in_en=0) change no counter, detector, or min/max state.
REQ-023 DONE holds outputs until next meas_start; meas_start in same cycle as meas_valid is accepted.
REQ-024 A 0->1 detector transition and a counter saturation on the same sample: crossing takes priority.
REQ-025 Samples in ACQ never cause crossings; detector is cleared on ACQ->SEEK.

Reset
REQ-026 rst forces state IDLE from any state, mid-measurement included, same-cycle as sampled.
REQ-027 Reset values: busy=0, meas_valid=0, vmax=0, vmin=0, period=0, err=00, detector disarmed, counters 0.
REQ-028 rst has priority over meas_start and data_in_en.

Configuration
REQ-029 Macro WAVE_ANALYZER_TIMEOUT_EN defined: counter reaching 0xFFFF in SEEK or MEAS -> DONE, err=10, period=0xFFFF.
REQ-030 Macro undefined: counter holds 0xFFFF and FSM waits indefinitely for crossings; err=10 never produced.

Structure
REQ-031 Shared package wave_pkg holds: state encoding, SAMPLE_W=10, CNT_W=16, err code constants.
REQ-032 One sub-module crossing_detect: inputs sample, valid, lo, hi, clear; output one-cycle rise pulse; holds armed flag.
REQ-033 Estimated 150-250 lines of RTL total.

Verification
REQ-034 Default params, 8-bit-step sawtooth 0..1023 period 128 samples, data_in_en=1 -> vmax=1023, vmin=0, period=128, err=00.
REQ-035 Constant data_in=512 -> after 1024 samples: meas_valid, err=01, period=0.
REQ-036 Sine of period 256 samples with data_in_en on every 3rd cycle -> period=256 (samples, not clocks).
REQ-037 rst pulse in MEAS after 2 crossings, then meas_start -> busy=0 cycle after rst; fresh run returns correct period.
REQ-038 Ramp reaching hi but never back below lo: with WAVE_ANALYZER_TIMEOUT_EN err=10, period=0xFFFF; without it busy stays 1.
REQ-039 Noise +-5 LSB around a 100-sample square wave, HYST=8 -> exactly one crossing per period, period=100.
